// File: rtl/lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: access widths, FSM states, exception causes.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWaitRsp = 2'd2,
        StDone    = 2'd3
    } lsu_state_e;

    localparam logic [1:0] EXC_ILLEGAL  = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_FAULT    = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store byte enables / replicated write data, and load lane extract with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] lane;

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_size_i)
            2'b00: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane      = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = lane;
        case (ld_func3_i)
            F3_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   ld_data_o = {24'h0, lane[7:0]};
            F3_HU:   ld_data_o = {16'h0, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: checks the access, runs one valid/ready bus transaction with a
// timeout, stalls the pipeline while it is outstanding, and returns extended load data.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] USER_BASE = 32'h0000_8000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] me_alu_o,
    input  logic [31:0] me_regs_data2,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    input  logic [2:0]  me_func3_code,
    input  logic [1:0]  me_priv_mode,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rdata,
    output logic        stall_o,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam int unsigned TimerW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        func3_q, func3_d;
    logic              ld_valid_q, ld_valid_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              exc_valid_q, exc_valid_d;
    logic [1:0]        exc_cause_q, exc_cause_d;
    logic [31:0]       exc_addr_q, exc_addr_d;

    logic        access, illegal, misaligned, fault, err, timeout;
    logic [1:0]  err_cause;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_extract;

    lsu_align u_align (
        .st_size_i  (me_func3_code[1:0]),
        .st_off_i   (me_alu_o[1:0]),
        .st_data_i  (me_regs_data2),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_func3_i (func3_q),
        .ld_off_i   (addr_q[1:0]),
        .ld_rdata_i (dbus_rdata),
        .ld_data_o  (ld_extract)
    );

    always_comb begin
        access     = me_mem_read | me_mem_write;
        illegal    = me_mem_write ? (me_func3_code > F3_W)
                                  : (me_func3_code == 3'b011 || me_func3_code[2:1] == 2'b11);
        misaligned = (me_func3_code[1:0] == 2'b01 && me_alu_o[0]) ||
                     (me_func3_code[1:0] == 2'b10 && me_alu_o[1:0] != 2'b00);
        fault      = (me_priv_mode == 2'b00) && (me_alu_o < USER_BASE);
        err        = access && (illegal || misaligned || fault);
        err_cause  = illegal ? EXC_ILLEGAL : (misaligned ? EXC_MISALIGN : EXC_FAULT);
        timeout    = (timer_q == TimerMax);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        stall_o     = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        unique case (state_q)
            StIdle: begin
                if (access && err) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = err_cause;
                    exc_addr_d  = me_alu_o;
                end else if (access) begin
                    stall_o = 1'b1;
                    state_d = StReq;
                    timer_d = '0;
                    we_d    = me_mem_write;
                    addr_d  = me_alu_o;
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    func3_d = me_func3_code;
                end
            end
            StReq: begin
                // Timeout wins over a same-cycle ready: the request is abandoned either way.
                if (timeout) begin
                    state_d     = StIdle;
                    exc_valid_d = 1'b1;
                    exc_cause_d = EXC_TIMEOUT;
                    exc_addr_d  = addr_q;
                end else begin
                    stall_o = 1'b1;
                    timer_d = timer_q + 1'b1;
                    if (dbus_req_ready) begin
                        state_d = StWaitRsp;
                    end
                end
            end
            StWaitRsp: begin
                if (dbus_rsp_valid) begin
                    stall_o = 1'b1;
                    state_d = StDone;
                    if (!we_q) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = ld_extract;
                    end
                end else if (timeout) begin
                    state_d     = StIdle;
                    exc_valid_d = 1'b1;
                    exc_cause_d = EXC_TIMEOUT;
                    exc_addr_d  = addr_q;
                end else begin
                    stall_o = 1'b1;
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            func3_q     <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            func3_q     <= func3_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign dbus_req_valid = (state_q == StReq);
    assign dbus_we        = we_q;
    assign dbus_addr      = {addr_q[31:2], 2'b00};
    assign dbus_be        = be_q;
    assign dbus_wdata     = wdata_q;
    assign ld_valid       = ld_valid_q;
    assign ld_data        = ld_data_q;
    assign exc_valid      = exc_valid_q;
    assign exc_cause      = exc_cause_q;
    assign exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised bench for mem_lsu: a driver predicts each access into scoreboard queues, a bus
// responder plays the memory, and a monitor pops and compares whenever the DUT presents output.
module tb_mem_lsu;

    localparam int unsigned TIMEOUT   = 16;
    localparam logic [31:0] USER_BASE = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] me_alu_o, me_regs_data2;
    logic        me_mem_read, me_mem_write;
    logic [2:0]  me_func3_code;
    logic [1:0]  me_priv_mode;
    logic        dbus_req_valid, dbus_req_ready, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        dbus_rsp_valid, stall_o, ld_valid, exc_valid;
    logic [31:0] ld_data, exc_addr;
    logic [1:0]  exc_cause;

    always #5 clk = ~clk;

    mem_lsu #(.USER_BASE(USER_BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2),
        .me_mem_read(me_mem_read), .me_mem_write(me_mem_write), .me_func3_code(me_func3_code),
        .me_priv_mode(me_priv_mode), .dbus_req_valid(dbus_req_valid),
        .dbus_req_ready(dbus_req_ready), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_rsp_valid(dbus_rsp_valid),
        .dbus_rdata(dbus_rdata), .stall_o(stall_o), .ld_valid(ld_valid), .ld_data(ld_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_t;
    typedef struct {
        logic [1:0]  cause;
        logic [31:0] addr;
    } exc_t;

    req_t        req_q[$];
    logic [31:0] ld_q[$];
    exc_t        exc_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bus responder settings, written by the driver only while no request is outstanding.
    int          slv_rdy_dly = 0;
    int          slv_rsp_dly = 0;
    logic [31:0] slv_rdata = '0;
    int          late_req = 0;

    initial begin
        int wcnt, rcnt, late_done;
        bit pend;
        wcnt = 0; rcnt = 0; late_done = 0; pend = 0;
        dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rdata = '0;
        forever begin
            @(posedge clk); #1;
            dbus_req_ready = 1'b0;
            dbus_rsp_valid = 1'b0;
            if (!rstn) begin
                pend = 0; wcnt = 0;
            end else if (pend) begin
                if (rcnt == slv_rsp_dly) begin
                    dbus_rsp_valid = 1'b1; dbus_rdata = slv_rdata; pend = 0;
                end else rcnt++;
            end else if (dbus_req_valid) begin
                if (wcnt == slv_rdy_dly) begin
                    dbus_req_ready = 1'b1; pend = 1; rcnt = 0; wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
            if (late_req != late_done) begin
                dbus_rsp_valid = 1'b1; dbus_rdata = 32'hFFFF_FFFF; late_done = late_req;
            end
        end
    end

    initial begin
        req_t r;
        exc_t e;
        logic [31:0] l;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (dbus_req_valid && dbus_req_ready) begin
                    if (req_q.size() == 0) chk("req_unexpected", 32'(dbus_req_ready), 32'd0);
                    else begin
                        r = req_q.pop_front();
                        chk("req_we", 32'(dbus_we), 32'(r.we));
                        chk("req_addr", dbus_addr, r.addr);
                        chk("req_be", 32'(dbus_be), 32'(r.be));
                        if (r.chk_wdata) chk("req_wdata", dbus_wdata, r.wdata);
                    end
                end
                if (ld_valid) begin
                    if (ld_q.size() == 0) chk("ld_unexpected", 32'(ld_valid), 32'd0);
                    else begin
                        l = ld_q.pop_front();
                        chk("ld_data", ld_data, l);
                    end
                end
                if (exc_valid) begin
                    if (exc_q.size() == 0) chk("exc_unexpected", 32'(exc_valid), 32'd0);
                    else begin
                        e = exc_q.pop_front();
                        chk("exc_cause", 32'(exc_cause), 32'(e.cause));
                        chk("exc_addr", exc_addr, e.addr);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        me_mem_read = 1'b0; me_mem_write = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(dbus_req_valid), 32'd0);
        chk({tag, "_payload"}, 32'(dbus_we) | 32'(dbus_be) | dbus_addr | dbus_wdata, 32'd0);
        chk({tag, "_ld"}, 32'(ld_valid) | ld_data, 32'd0);
        chk({tag, "_exc"}, 32'(exc_valid) | 32'(exc_cause) | exc_addr, 32'd0);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    endtask

    // One pipeline instruction in MEM; expectations come from the access rules, not the FSM.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3, input logic [1:0] priv,
                          input int rdy, input int rsp, input logic [31:0] rdata,
                          input bit expect_timeout);
        int unsigned size, a, nbytes, exp_stall, stalls;
        bit illegal, mis, fault, err, done;
        logic [31:0] lane, v;
        req_t r;
        exc_t e;
        size    = 32'(f3[1:0]);
        a       = 32'(addr[1:0]);
        illegal = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis     = (size == 1 && addr[0]) || (size == 2 && a != 0);
        fault   = (priv == 2'b00) && (addr < USER_BASE);
        err     = (rd || wr) && (illegal || mis || fault);
        exp_stall = 0;
        if (err) begin
            e.cause = illegal ? 2'd0 : (mis ? 2'd1 : 2'd2);
            e.addr  = addr;
            exc_q.push_back(e);
        end else if (rd || wr) begin
            if (expect_timeout) begin
                e.cause = 2'd3; e.addr = addr;
                exc_q.push_back(e);
                exp_stall = TIMEOUT;
            end else begin
                nbytes = 1 << size;
                r.we = wr;
                r.addr = addr & 32'hFFFF_FFFC;
                r.be = 4'(((1 << nbytes) - 1) << a);
                r.wdata = (size == 0) ? (data & 32'hFF) * 32'h0101_0101 :
                          (size == 1) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
                r.chk_wdata = wr;
                req_q.push_back(r);
                if (rd) begin
                    lane = rdata >> (8 * a);
                    if (size == 0) begin
                        v = lane & 32'hFF;
                        if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
                    end else if (size == 1) begin
                        v = lane & 32'hFFFF;
                        if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
                    end else v = lane;
                    ld_q.push_back(v);
                end
                exp_stall = 3 + rdy + rsp;
            end
        end
        slv_rdy_dly = rdy; slv_rsp_dly = rsp; slv_rdata = rdata;
        me_mem_read = rd; me_mem_write = wr; me_alu_o = addr; me_regs_data2 = data;
        me_func3_code = f3; me_priv_mode = priv;
        stalls = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            else done = 1;
            @(posedge clk); #1;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL stall_bound: got still stalled expected release within 200 cycles");
        end
        chk("stall_cycles", stalls, exp_stall);
        idle_inputs();
        if (err || expect_timeout) begin
            @(negedge clk);
            chk("no_req_after_exc", 32'(dbus_req_valid), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        req_t r;
        idle_inputs();
        me_alu_o = '0; me_regs_data2 = '0; me_func3_code = '0; me_priv_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        access(0, 1, 32'h9004, 32'hDEAD_BEEF, 3'b010, 2'b11, 0, 0, 32'h0, 0);
        access(1, 0, 32'h9003, 32'h0, 3'b000, 2'b11, 0, 0, 32'h80FF_0000, 0);
        access(1, 0, 32'h9003, 32'h0, 3'b100, 2'b11, 1, 2, 32'h80FF_0000, 0);
        access(1, 0, 32'h9001, 32'h0, 3'b001, 2'b11, 0, 0, 32'h0, 0);
        access(1, 0, 32'h4000, 32'h0, 3'b010, 2'b00, 0, 0, 32'h0, 0);
        access(1, 0, 32'h4000, 32'h0, 3'b010, 2'b11, 0, 0, 32'h1234_5678, 0);
        access(0, 1, 32'h9000, 32'h0, 3'b100, 2'b11, 0, 0, 32'h0, 0);

        // Bus never accepts: timeout, then a stray response must be ignored.
        access(1, 0, 32'h9010, 32'h0, 3'b010, 2'b11, 1000, 0, 32'h0, 1);
        late_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rsp_stall", 32'(stall_o), 32'd0);
            @(posedge clk); #1;
        end

        // Reset while waiting for a response.
        r.we = 0; r.addr = 32'h9008; r.be = 4'hF; r.wdata = '0; r.chk_wdata = 0;
        req_q.push_back(r);
        slv_rdy_dly = 0; slv_rsp_dly = 50; slv_rdata = 32'h0;
        me_mem_read = 1; me_alu_o = 32'h9008; me_func3_code = 3'b010; me_priv_mode = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rstn = 1'b1;
        access(0, 1, 32'h9002, 32'h0000_1234, 3'b001, 2'b11, 0, 0, 32'h0, 0);

        for (int n = 0; n < 80; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 4);
            access(kind inside {0, 1}, kind inside {2, 3},
                   ($urandom_range(0, 1) ? 32'h9000 : 32'h4000) + $urandom_range(0, 255),
                   $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0 ? 2'b11 : 2'b00,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("ld_q_empty", ld_q.size(), 32'd0);
        chk("exc_q_empty", exc_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
